program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writes user-entered instruction words into the instruction ROM. The CPU only reads that ROM.
- A debounced store button captures the 16 switches into sequential ROM addresses starting at 0.
- While loading, the block holds the CPU in reset. A run button releases the CPU to execute the loaded program.
- Sits between the board switches/buttons and the write port of the 32K-word instruction memory.

Parameters:
- ADDR_W, 15, ROM address width.
- DATA_W, 16, instruction word width.
- MAX_WORDS, 32768, ROM capacity in words; must be ≤ 2^ADDR_W.
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles needed to accept a button level change.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- switches  in  DATA_W  instruction word to store.
- storeBtn  in  1  raw, asynchronous push button; writes one word.
- runBtn  in  1  raw, asynchronous push button; toggles LOAD/RUN.
- romQ  in  DATA_W  ROM read data at romAddress; used only by the optional feature.
- romAddress  out  ADDR_W  ROM write address.
- romData  out  DATA_W  ROM write data.
- romWrite  out  1  ROM write enable; one-cycle pulse.
- cpuReset  out  1  active-high CPU reset; high except in RUN.
- wordCount  out  ADDR_W+1  number of words stored since last clear.
- full  out  1  wordCount == MAX_WORDS.
- loading  out  1  high in LOAD/WRITE/VERIFY states.
- verifyErr  out  1  sticky readback mismatch flag (optional feature).

Behaviour:
- Reset (reset=0, asynchronous), every output driven at once:
  - state=LOAD; romAddress=0, romData=0, romWrite=0.
  - cpuReset=1, wordCount=0, full=0, loading=1, verifyErr=0.
  - Debouncers cleared to released.
- Button conditioning, each button separately:
  - 2-FF synchroniser, then a debounce counter.
  - The debounced level flips after DEBOUNCE_CYCLES consecutive cycles where the synced level differs from the current debounced level. Any bounce restarts the count.
  - A press event is a single-cycle pulse on the rising edge of the debounced level. Release generates nothing.
- FSM states: LOAD, WRITE, VERIFY (macro only), RUN.
- LOAD:
  - Store event and !full → capture switches into romData on that edge; go to WRITE.
  - Store event and full → ignored; no write, no count change.
  - Run event → RUN.
  - Store and run events in the same cycle → store is processed and the run event is dropped.
- WRITE (exactly 1 cycle):
  - romWrite=1 with romAddress and romData stable.
  - Next edge: romAddress += 1, wordCount += 1, then → LOAD (or → VERIFY if the macro is defined).
  - romAddress wraps to 0 after MAX_WORDS-1; full blocks any further writes.
- RUN:
  - cpuReset=0, loading=0, romWrite=0; store events ignored.
  - Run event → LOAD, with romAddress=0, wordCount=0 and full=0 on the same edge. cpuReset rises on that edge.
- Output timing:
  - cpuReset is registered and changes on the same edge as the state.
  - full is combinational from wordCount.
- Button events while in WRITE/VERIFY are dropped.
- Reset asserted mid-WRITE: romWrite falls immediately and the partially written word is not counted.
- Write latency: romWrite is high on the cycle after the store press event is registered.

Optional Feature:
- Macro: LOADER_VERIFY_EN.
- Defined:
  - After WRITE, enter VERIFY for 2 cycles. romAddress is held at the written address with romWrite=0.
  - On the second cycle, compare romQ to romData. On mismatch set verifyErr (sticky until reset).
  - Then increment address/count and return to LOAD.
- Undefined:
  - No VERIFY state; romQ is ignored; verifyErr is tied to 0.
  - WRITE increments address/count directly.

Test Plan (bench uses DEBOUNCE_CYCLES=4, MAX_WORDS=4):
- Reset low then high; no buttons → romWrite=0, cpuReset=1, loading=1, wordCount=0, romAddress=0.
- switches=16'h0005, clean store press → one romWrite pulse at address 0 with data 0005; afterwards wordCount=1, romAddress=1.
- storeBtn bouncing 0/1 every 2 cycles for 20 cycles, then stable high → exactly one write.
- Store 4 words (0x1111, 0x2222, 0x3333, 0x4444), then a fifth press → full=1, no fifth romWrite, wordCount=4.
- Run press → cpuReset=0. Store press in RUN → no write. Second run press → cpuReset=1, wordCount=0, romAddress=0.
- Reset driven low during a WRITE cycle → romWrite deasserts immediately, wordCount=0.
- With LOADER_VERIFY_EN, bench ROM model corrupts address 2 → verifyErr=1 after the third store and stays 1.

Source files
------------

// File: rtl/program_loader.sv
// Program loader: debounced store/run buttons write switch words into the instruction ROM
// and hold the CPU in reset while loading. Define LOADER_VERIFY_EN to add ROM readback checking.

module program_loader_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             level_d_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise the raw button and only accept a level held long enough without bouncing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      sync1_r   <= btn;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= ~level_r;
          cnt_r   <= {CNT_W{1'b0}};
        end else begin
          cnt_r   <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  assign press = level_r & ~level_d_r;
endmodule

module program_loader #(
  parameter int ADDR_W          = 15,
  parameter int DATA_W          = 16,
  parameter int MAX_WORDS       = 32768,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] switches,
  input  logic              storeBtn,
  input  logic              runBtn,
  input  logic [DATA_W-1:0] romQ,
  output logic [ADDR_W-1:0] romAddress,
  output logic [DATA_W-1:0] romData,
  output logic              romWrite,
  output logic              cpuReset,
  output logic [ADDR_W:0]   wordCount,
  output logic              full,
  output logic              loading,
  output logic              verifyErr
);
  localparam logic [ADDR_W:0]   MAX_CNT   = (ADDR_W + 1)'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic              store_evt_s;
  logic              run_evt_s;
  logic              full_s;
  logic              advance_s;
  logic [ADDR_W-1:0] rom_address_r;
  logic [ADDR_W-1:0] rom_address_nx_s;
  logic [DATA_W-1:0] rom_data_r;
  logic [DATA_W-1:0] rom_data_nx_s;
  logic [ADDR_W:0]   word_count_r;
  logic [ADDR_W:0]   word_count_nx_s;
  logic              rom_write_r;
  logic              cpu_reset_r;
  logic              loading_r;
  logic              verify_err_r;
  logic              verify_err_nx_s;
`ifdef LOADER_VERIFY_EN
  logic              verify_cnt_r;
  logic              verify_cnt_nx_s;
`else
  logic              unused_romq_s;
  assign unused_romq_s = ^romQ;
`endif

  program_loader_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_store_db (
    .clk   (clk),
    .reset (reset),
    .btn   (storeBtn),
    .press (store_evt_s)
  );

  program_loader_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk   (clk),
    .reset (reset),
    .btn   (runBtn),
    .press (run_evt_s)
  );

  assign full_s = (word_count_r == MAX_CNT);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; a store event in LOAD always wins over a simultaneous run event
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (store_evt_s) begin
          state_nx_s = full_s ? ST_LOAD : ST_WRITE;
        end else if (run_evt_s) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
`ifdef LOADER_VERIFY_EN
      ST_WRITE:  state_nx_s = ST_VERIFY;
      ST_VERIFY: begin
        if (verify_cnt_r) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_VERIFY;
        end
      end
`else
      ST_WRITE:  state_nx_s = ST_LOAD;
`endif
      ST_RUN: begin
        if (run_evt_s) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: state_nx_s = ST_LOAD;
    endcase
  end

  // Output/datapath next values; the address and count advance only once a word is fully handled
  always_comb begin
    rom_address_nx_s = rom_address_r;
    rom_data_nx_s    = rom_data_r;
    word_count_nx_s  = word_count_r;
    verify_err_nx_s  = verify_err_r;
    advance_s        = 1'b0;
`ifdef LOADER_VERIFY_EN
    verify_cnt_nx_s  = 1'b0;
`endif
    case (state_r)
      ST_LOAD: begin
        if (store_evt_s && !full_s) begin
          rom_data_nx_s = switches;
        end else begin
          rom_data_nx_s = rom_data_r;
        end
      end
`ifdef LOADER_VERIFY_EN
      ST_WRITE: verify_cnt_nx_s = 1'b0;
      ST_VERIFY: begin
        if (verify_cnt_r) begin
          advance_s = 1'b1;
          if (romQ != rom_data_r) begin
            verify_err_nx_s = 1'b1;
          end else begin
            verify_err_nx_s = verify_err_r;
          end
        end else begin
          verify_cnt_nx_s = 1'b1;
        end
      end
`else
      ST_WRITE: advance_s = 1'b1;
`endif
      ST_RUN: begin
        if (run_evt_s) begin
          rom_address_nx_s = {ADDR_W{1'b0}};
          word_count_nx_s  = {(ADDR_W + 1){1'b0}};
        end else begin
          rom_address_nx_s = rom_address_r;
          word_count_nx_s  = word_count_r;
        end
      end
      default: advance_s = 1'b0;
    endcase
    if (advance_s) begin
      rom_address_nx_s = (rom_address_r == LAST_ADDR) ? {ADDR_W{1'b0}}
                                                      : rom_address_r + ADDR_W'(1);
      word_count_nx_s  = word_count_r + (ADDR_W + 1)'(1);
    end else begin
      rom_address_nx_s = rom_address_nx_s;
    end
  end

  // Output registers; control outputs follow the next state so they change with the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_address_r <= {ADDR_W{1'b0}};
      rom_data_r    <= {DATA_W{1'b0}};
      word_count_r  <= {(ADDR_W + 1){1'b0}};
      rom_write_r   <= 1'b0;
      cpu_reset_r   <= 1'b1;
      loading_r     <= 1'b1;
      verify_err_r  <= 1'b0;
`ifdef LOADER_VERIFY_EN
      verify_cnt_r  <= 1'b0;
`endif
    end else begin
      rom_address_r <= rom_address_nx_s;
      rom_data_r    <= rom_data_nx_s;
      word_count_r  <= word_count_nx_s;
      rom_write_r   <= (state_nx_s == ST_WRITE);
      cpu_reset_r   <= (state_nx_s != ST_RUN);
      loading_r     <= (state_nx_s != ST_RUN);
      verify_err_r  <= verify_err_nx_s;
`ifdef LOADER_VERIFY_EN
      verify_cnt_r  <= verify_cnt_nx_s;
`endif
    end
  end

  assign romAddress = rom_address_r;
  assign romData    = rom_data_r;
  assign romWrite   = rom_write_r;
  assign cpuReset   = cpu_reset_r;
  assign wordCount  = word_count_r;
  assign full       = full_s;
  assign loading    = loading_r;
  assign verifyErr  = verify_err_r;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with a small ROM model and a behavioural loader model.
module tb_program_loader;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int MAXW   = 4;
  localparam int DEB    = 4;
`ifdef LOADER_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  typedef logic [ADDR_W+DATA_W-1:0] wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] switches = '0;
  logic              storeBtn = 1'b0;
  logic              runBtn = 1'b0;
  logic [DATA_W-1:0] romQ;
  logic [ADDR_W-1:0] romAddress;
  logic [DATA_W-1:0] romData;
  logic              romWrite;
  logic              cpuReset;
  logic [ADDR_W:0]   wordCount;
  logic              full;
  logic              loading;
  logic              verifyErr;

  int  checks = 0;
  int  failures = 0;
  wr_t wr_q[$];
  wr_t exp_q[$];
  int  m_count, m_addr;
  bit  m_run, m_verr;
  logic [DATA_W-1:0] rom_mem [0:3];

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(MAXW), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .switches(switches), .storeBtn(storeBtn), .runBtn(runBtn),
    .romQ(romQ), .romAddress(romAddress), .romData(romData), .romWrite(romWrite),
    .cpuReset(cpuReset), .wordCount(wordCount), .full(full), .loading(loading),
    .verifyErr(verifyErr)
  );

  always #5 clk = ~clk;

  // ROM model: address 2 reads back with one bit flipped
  always @(posedge clk) if (romWrite) rom_mem[romAddress[1:0]] <= romData;
  assign romQ = rom_mem[romAddress[1:0]] ^ ((romAddress == 15'd2) ? 16'h0100 : 16'h0000);

  always @(negedge clk) if (reset && romWrite) wr_q.push_back({romAddress, romData});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    m_count = 0; m_addr = 0; m_run = 1'b0; m_verr = 1'b0;
    exp_q.delete(); wr_q.delete();
  endtask

  task automatic apply_reset();
    storeBtn = 1'b0; runBtn = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse(input bit is_run);
    @(posedge clk); #1;
    if (is_run) runBtn = 1'b1; else storeBtn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    if (is_run) runBtn = 1'b0; else storeBtn = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_store(input logic [DATA_W-1:0] d);
    if (!m_run && m_count < MAXW) begin
      exp_q.push_back({ADDR_W'(m_addr), d});
      if (VERIFY_ON && m_addr == 2) m_verr = 1'b1;
      m_addr = (m_addr + 1) % MAXW;
      m_count++;
    end
  endtask

  task automatic do_store(input logic [DATA_W-1:0] d);
    @(posedge clk); #1 switches = d;
    pulse(1'b0);
    model_store(d);
  endtask

  task automatic do_run();
    pulse(1'b1);
    if (m_run) begin m_run = 1'b0; m_addr = 0; m_count = 0; end
    else m_run = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1 reset = 1'b0;
    #1;
    checks++; if (romWrite !== 1'b0 || cpuReset !== 1'b1 || loading !== 1'b1) begin
      failures++; $display("FAIL reset_ctrl: got w=%b c=%b l=%b expected 0 1 1", romWrite, cpuReset, loading); end
    checks++; if (wordCount !== '0 || romAddress !== '0 || full !== 1'b0 || verifyErr !== 1'b0) begin
      failures++; $display("FAIL reset_data: got cnt=%0d addr=%0d full=%b verr=%b expected zeros", wordCount, romAddress, full, verifyErr); end
    apply_reset();
    @(negedge clk);
    checks++; if (romWrite !== 1'b0 || cpuReset !== 1'b1 || loading !== 1'b1 || wordCount !== '0 || romAddress !== '0) begin
      failures++; $display("FAIL idle_after_reset: got w=%b c=%b l=%b cnt=%0d addr=%0d", romWrite, cpuReset, loading, wordCount, romAddress); end
  endtask

  task automatic test_single_store();
    do_store(16'h0005);
    checks++; if (wr_q.size() !== 1 || (wr_q.size() == 1 && wr_q[0] !== {15'd0, 16'h0005})) begin
      failures++; $display("FAIL single_write: got n=%0d first=%h expected 1 entry %h", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0, {15'd0, 16'h0005}); end
    checks++; if (wordCount !== 16'(m_count) || romAddress !== 15'(m_addr)) begin
      failures++; $display("FAIL single_count: got cnt=%0d addr=%0d expected %0d %0d", wordCount, romAddress, m_count, m_addr); end
    wr_q.delete(); exp_q.delete();
  endtask

  task automatic test_bounce();
    logic [DATA_W-1:0] d;
    d = 16'($urandom);
    @(posedge clk); #1 switches = d;
    for (int i = 0; i < 10; i++) begin
      storeBtn = ~storeBtn;
      repeat (2) @(posedge clk);
      #1;
    end
    storeBtn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wr_q.size() !== 0) begin
      failures++; $display("FAIL bounce_no_write: got %0d writes expected 0", wr_q.size()); end
    pulse(1'b0);
    model_store(d);
    checks++; if (wr_q.size() !== exp_q.size() || (wr_q.size() == 1 && wr_q[0] !== exp_q[0])) begin
      failures++; $display("FAIL bounce_one_write: got n=%0d expected n=%0d data %h", wr_q.size(), exp_q.size(), d); end
    checks++; if (wordCount !== 16'(m_count)) begin
      failures++; $display("FAIL bounce_count: got %0d expected %0d", wordCount, m_count); end
    wr_q.delete(); exp_q.delete();
  endtask

  task automatic test_fill();
    logic [DATA_W-1:0] words [4];
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_store(words[i]);
      checks++; if (verifyErr !== m_verr) begin
        failures++; $display("FAIL fill_verify_err[%0d]: got %b expected %b", i, verifyErr, m_verr); end
    end
    do_store(16'($urandom));
    checks++; if (full !== 1'b1 || wordCount !== 16'(MAXW) || romAddress !== 15'(m_addr)) begin
      failures++; $display("FAIL fill_full: got full=%b cnt=%0d addr=%0d expected 1 %0d %0d", full, wordCount, romAddress, MAXW, m_addr); end
    checks++; if (wr_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL fill_write_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
    else for (int i = 0; i < wr_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL fill_write[%0d]: got %h expected %h", i, wr_q[i], exp_q[i]); end
    end
    wr_q.delete(); exp_q.delete();
  endtask

  task automatic test_run();
    do_run();
    checks++; if (cpuReset !== 1'b0 || loading !== 1'b0 || romWrite !== 1'b0) begin
      failures++; $display("FAIL run_enter: got c=%b l=%b w=%b expected 0 0 0", cpuReset, loading, romWrite); end
    apply_store_in_run();
    do_run();
    checks++; if (cpuReset !== 1'b1 || loading !== 1'b1 || wordCount !== 16'(m_count) || romAddress !== 15'(m_addr) || full !== 1'b0) begin
      failures++; $display("FAIL run_exit: got c=%b l=%b cnt=%0d addr=%0d full=%b expected 1 1 0 0 0", cpuReset, loading, wordCount, romAddress, full); end
    for (int i = 0; i < 2; i++) do_store(16'($urandom));
    checks++; if (wr_q.size() !== 2 || (wr_q.size() == 2 && (wr_q[0] !== exp_q[0] || wr_q[1] !== exp_q[1]))) begin
      failures++; $display("FAIL reload_writes: got n=%0d expected 2 writes from address 0", wr_q.size()); end
    wr_q.delete(); exp_q.delete();
  endtask

  task automatic apply_store_in_run();
    do_store(16'($urandom));
    checks++; if (wr_q.size() !== 0 || cpuReset !== 1'b0 || wordCount !== 16'(m_count)) begin
      failures++; $display("FAIL run_store_ignored: got n=%0d c=%b cnt=%0d expected 0 0 %0d", wr_q.size(), cpuReset, wordCount, m_count); end
  endtask

  task automatic test_write_reset();
    int n;
    apply_reset();
    @(posedge clk); #1 switches = 16'($urandom); storeBtn = 1'b1;
    n = 0;
    while (romWrite !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (romWrite !== 1'b1) begin
      failures++; $display("FAIL write_wait: got romWrite=%b expected 1 within 40 cycles", romWrite); end
    reset = 1'b0;
    #1;
    checks++; if (romWrite !== 1'b0 || wordCount !== '0 || cpuReset !== 1'b1) begin
      failures++; $display("FAIL write_reset: got w=%b cnt=%0d c=%b expected 0 0 1", romWrite, wordCount, cpuReset); end
    storeBtn = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_clear();
    do_store(16'($urandom));
    checks++; if (wr_q.size() !== 1 || (wr_q.size() == 1 && wr_q[0] !== exp_q[0]) || wordCount !== 16'd1) begin
      failures++; $display("FAIL after_write_reset: got n=%0d cnt=%0d expected 1 write at address 0", wr_q.size(), wordCount); end
    wr_q.delete(); exp_q.delete();
  endtask

  task automatic test_verify();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_store(16'($urandom));
      checks++; if (verifyErr !== m_verr) begin
        failures++; $display("FAIL verify_err[%0d]: got %b expected %b", i, verifyErr, m_verr); end
    end
    checks++; if (wr_q.size() !== 4 || wordCount !== 16'(MAXW)) begin
      failures++; $display("FAIL verify_writes: got n=%0d cnt=%0d expected 4 4", wr_q.size(), wordCount); end
    wr_q.delete(); exp_q.delete();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_store();
    test_bounce();
    test_fill();
    test_run();
    test_write_reset();
    if (VERIFY_ON) test_verify();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
